// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard control between ID decode and the ID/EX register.
// Optional saturating stall/forward counters are enabled with FWD_HAZARD_STATS_EN.
module fwd_hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_we,
  input  logic              id_is_load,
  input  logic              flush,
  output logic [1:0]        ex_sel_a,
  output logic [1:0]        ex_sel_b,
  output logic              ex_valid,
  output logic              stall
`ifdef FWD_HAZARD_STATS_EN
  ,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       fwd_cnt
`endif
);

  // A producer seen in WB while the consumer is in ID sits in RET once the consumer
  // reaches EX, so the RET slot never feeds a decision and is not stored.
  logic              ex_vld_q, ex_we_q, ex_ld_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic              mem_vld_q, mem_we_q;
  logic [REG_AW-1:0] mem_rd_q;
  logic              wb_vld_q, wb_we_q;
  logic [REG_AW-1:0] wb_rd_q;
  logic [1:0]        sel_a_q, sel_b_q;

  logic              zero_a, zero_b;
  logic              hit_ex_a, hit_mem_a, hit_wb_a;
  logic              hit_ex_b, hit_mem_b, hit_wb_b;
  logic              entry_v;
  logic [1:0]        sel_a_d, sel_b_d;

  always_comb begin
    zero_a    = (ZERO_REG != 0) && (id_rs1 == '0);
    zero_b    = (ZERO_REG != 0) && (id_rs2 == '0);
    hit_ex_a  = ex_vld_q  & ex_we_q  & id_use_rs1 & (ex_rd_q  == id_rs1) & ~zero_a;
    hit_mem_a = mem_vld_q & mem_we_q & id_use_rs1 & (mem_rd_q == id_rs1) & ~zero_a;
    hit_wb_a  = wb_vld_q  & wb_we_q  & id_use_rs1 & (wb_rd_q  == id_rs1) & ~zero_a;
    hit_ex_b  = ex_vld_q  & ex_we_q  & id_use_rs2 & (ex_rd_q  == id_rs2) & ~zero_b;
    hit_mem_b = mem_vld_q & mem_we_q & id_use_rs2 & (mem_rd_q == id_rs2) & ~zero_b;
    hit_wb_b  = wb_vld_q  & wb_we_q  & id_use_rs2 & (wb_rd_q  == id_rs2) & ~zero_b;

    stall   = id_valid & ~flush & ex_ld_q & (hit_ex_a | hit_ex_b);
    entry_v = id_valid & ~stall & ~flush;

    sel_a_d = 2'b00;
    sel_b_d = 2'b00;
    if (entry_v) begin
      if      (hit_ex_a)  sel_a_d = 2'b01;
      else if (hit_mem_a) sel_a_d = 2'b10;
      else if (hit_wb_a)  sel_a_d = 2'b11;
      if      (hit_ex_b)  sel_b_d = 2'b01;
      else if (hit_mem_b) sel_b_d = 2'b10;
      else if (hit_wb_b)  sel_b_d = 2'b11;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_vld_q  <= 1'b0;
      ex_we_q   <= 1'b0;
      ex_ld_q   <= 1'b0;
      ex_rd_q   <= '0;
      mem_vld_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_rd_q  <= '0;
      wb_vld_q  <= 1'b0;
      wb_we_q   <= 1'b0;
      wb_rd_q   <= '0;
      sel_a_q   <= 2'b00;
      sel_b_q   <= 2'b00;
    end else begin
      ex_vld_q  <= entry_v;
      ex_we_q   <= entry_v & id_we;
      ex_ld_q   <= entry_v & id_is_load;
      ex_rd_q   <= id_rd;
      mem_vld_q <= ex_vld_q;
      mem_we_q  <= ex_we_q;
      mem_rd_q  <= ex_rd_q;
      wb_vld_q  <= mem_vld_q;
      wb_we_q   <= mem_we_q;
      wb_rd_q   <= mem_rd_q;
      sel_a_q   <= sel_a_d;
      sel_b_q   <= sel_b_d;
    end
  end

  assign ex_sel_a = sel_a_q;
  assign ex_sel_b = sel_b_q;
  assign ex_valid = ex_vld_q;

`ifdef FWD_HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, fwd_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
      if (ex_vld_q && (sel_a_q != 2'b00 || sel_b_q != 2'b00) && fwd_cnt_q != 16'hFFFF)
        fwd_cnt_q <= fwd_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed plus randomized bench for fwd_hazard_ctrl against an instruction-age reference model.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       id_use_rs1, id_use_rs2, id_we, id_is_load, flush;
  logic [1:0] ex_sel_a, ex_sel_b;
  logic       ex_valid, stall;
`ifdef FWD_HAZARD_STATS_EN
  logic [15:0] stall_cnt, fwd_cnt;
`endif

  fwd_hazard_ctrl #(.REG_AW(5), .ZERO_REG(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .id_rd      (id_rd),
    .id_we      (id_we),
    .id_is_load (id_is_load),
    .flush      (flush),
    .ex_sel_a   (ex_sel_a),
    .ex_sel_b   (ex_sel_b),
    .ex_valid   (ex_valid),
    .stall      (stall)
`ifdef FWD_HAZARD_STATS_EN
    ,
    .stall_cnt  (stall_cnt),
    .fwd_cnt    (fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  // hist[0] is the instruction that entered EX most recently, hist[2] the oldest tracked.
  typedef struct packed {
    logic       v;
    logic       we;
    logic       ld;
    logic [4:0] rd;
  } instr_t;

  instr_t hist [3];
  int     n_chk  = 0;
  int     n_fail = 0;
  int     m_stall_cnt = 0;
  int     m_fwd_cnt   = 0;
  logic       m_exv = 1'b0;
  logic [1:0] m_sa  = 2'b00;
  logic [1:0] m_sb  = 2'b00;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Distance (in instructions) to the youngest tracked writer of rs; 0 when none.
  function automatic int age_of(input logic [4:0] rs, input logic use_rs);
    if (!use_rs || rs == 5'd0) return 0;
    for (int d = 0; d < 3; d++)
      if (hist[d].v && hist[d].we && hist[d].rd == rs) return d + 1;
    return 0;
  endfunction

  task automatic step(input logic rst, input logic v,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic we, input logic ld,
                      input logic fl, output logic stalled);
    logic       st_e, exv_e;
    logic [1:0] sa_e, sb_e;
    reset = rst; id_valid = v; id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2;
    id_use_rs2 = u2; id_rd = rd; id_we = we; id_is_load = ld; flush = fl;
    #1;
    st_e = v && !fl && hist[0].v && hist[0].we && hist[0].ld &&
           ((age_of(rs1, u1) == 1) || (age_of(rs2, u2) == 1));
    if (!rst) chk("stall", 16'(stall), 16'(st_e));
    exv_e = v && !st_e && !fl && !rst;
    sa_e  = exv_e ? 2'(age_of(rs1, u1)) : 2'b00;
    sb_e  = exv_e ? 2'(age_of(rs2, u2)) : 2'b00;
    if (rst) begin
      m_stall_cnt = 0;
      m_fwd_cnt   = 0;
    end else begin
      if (st_e && m_stall_cnt < 65535) m_stall_cnt++;
      if (m_exv && (m_sa != 2'b00 || m_sb != 2'b00) && m_fwd_cnt < 65535) m_fwd_cnt++;
    end
    @(posedge clk);
    #1;
    chk("ex_valid", 16'(ex_valid), 16'(exv_e));
    if (v || rst) begin
      chk("ex_sel_a", 16'(ex_sel_a), 16'(sa_e));
      chk("ex_sel_b", 16'(ex_sel_b), 16'(sb_e));
    end
    if (rst) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      chk("rst_stall", 16'(stall), 16'h0);
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = '{v: exv_e, we: exv_e && we, ld: exv_e && ld, rd: rd};
    end
    m_exv = exv_e; m_sa = sa_e; m_sb = sb_e;
`ifdef FWD_HAZARD_STATS_EN
    chk("stall_cnt", stall_cnt, 16'(m_stall_cnt));
    chk("fwd_cnt", fwd_cnt, 16'(m_fwd_cnt));
`endif
    stalled = st_e;
  endtask

  // Presents one instruction, holding it across any stall cycles as upstream would.
  task automatic issue(input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we, input logic ld,
                       input logic fl, output int n_stall);
    logic st;
    n_stall = 0;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, rs1, u1, rs2, u2, rd, we, ld, fl, st);
      if (!st) return;
      n_stall++;
    end
    chk("stall_budget", 16'(n_stall), 16'd1);
  endtask

  initial begin
    logic st;
    int   ns;
    for (int i = 0; i < 3; i++) hist[i] = '0;
    reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_we = 1'b0; id_is_load = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, st);
    chk("reset_exv", 16'(ex_valid), 16'h0);
    chk("reset_sel", 16'({ex_sel_a, ex_sel_b}), 16'h0);

    // back-to-back ALU
    issue(5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, ns);
    issue(5'd3, 1, 5'd3, 1, 5'd5, 1, 0, 0, ns);
    chk("b2b_sel_a", 16'(ex_sel_a), 16'h1);
    chk("b2b_sel_b", 16'(ex_sel_b), 16'h1);
    chk("b2b_nostall", 16'(ns), 16'h0);

    // distance 2, 3, 4
    for (int gap = 1; gap <= 3; gap++) begin
      issue(5'd8, 1, 5'd9, 1, 5'd4, 1, 0, 0, ns);
      for (int g = 0; g < gap; g++) issue(5'd8, 1, 5'd9, 1, 5'd7, 1, 0, 0, ns);
      issue(5'd4, 1, 5'd9, 0, 5'd10, 1, 0, 0, ns);
      chk("dist_sel_a", 16'(ex_sel_a), (gap == 1) ? 16'h2 : (gap == 2) ? 16'h3 : 16'h0);
    end

    // load-use
    issue(5'd8, 1, 5'd9, 0, 5'd2, 1, 1, 0, ns);
    issue(5'd2, 1, 5'd1, 1, 5'd6, 1, 0, 0, ns);
    chk("lu_stalls", 16'(ns), 16'h1);
    chk("lu_sel_a", 16'(ex_sel_a), 16'h2);
    chk("lu_sel_b", 16'(ex_sel_b), 16'h0);

    // zero register
    issue(5'd8, 1, 5'd9, 1, 5'd0, 1, 0, 0, ns);
    issue(5'd0, 1, 5'd0, 1, 5'd11, 1, 0, 0, ns);
    chk("zero_sel_a", 16'(ex_sel_a), 16'h0);
    issue(5'd8, 1, 5'd9, 1, 5'd0, 1, 1, 0, ns);
    issue(5'd0, 1, 5'd0, 1, 5'd11, 1, 0, 0, ns);
    chk("zero_ld_nostall", 16'(ns), 16'h0);

    // flush during load-use, then a reader of the load still forwards from MEM
    issue(5'd8, 1, 5'd9, 0, 5'd2, 1, 1, 0, ns);
    issue(5'd2, 1, 5'd1, 1, 5'd6, 1, 0, 1, ns);
    chk("flush_nostall", 16'(ns), 16'h0);
    chk("flush_exv", 16'(ex_valid), 16'h0);
    issue(5'd2, 1, 5'd1, 0, 5'd6, 1, 0, 0, ns);
    chk("flush_mem_fwd", 16'(ex_sel_a), 16'h2);

    // reset mid-stream with hazards pending
    issue(5'd8, 1, 5'd9, 1, 5'd3, 1, 0, 0, ns);
    issue(5'd8, 1, 5'd9, 1, 5'd5, 1, 1, 0, ns);
    step(1'b1, 1'b1, 5'd5, 1'b1, 5'd3, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0, st);

    // randomized traffic over a small register set to provoke frequent hazards
    for (int n = 0; n < 400; n++) begin
      logic [4:0] r1, r2, rd;
      r1 = 5'($urandom_range(0, 3));
      r2 = 5'($urandom_range(0, 3));
      rd = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 2)
        step(1'b1, 1'b1, r1, 1'b1, r2, 1'b1, rd, 1'b1, 1'b0, 1'b0, st);
      else if ($urandom_range(0, 99) < 15)
        step(1'b0, 1'b0, r1, 1'($urandom), r2, 1'($urandom), rd, 1'($urandom), 1'b0,
             1'($urandom_range(0, 9) == 0), st);
      else
        issue(r1, 1'($urandom), r2, 1'($urandom), rd, 1'($urandom_range(0, 3) != 0),
              1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 9) == 0), ns);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
